// File: rtl/decode_exec_reg_way1_pkg.sv
// Shared decode/execute types: payload bundle, bundle width and skid FSM states.
// Optional macro INST_ADDR_TRACE_EN adds a 32-bit instruction address to the bundle.
package core_pkg;

    localparam int CORE_DATA_W = 64;
    localparam int CORE_PID_W  = 2;

    // Occupancy of a main+skid register pair.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    // Payload handed from the way1 decoder to the way1 execute unit (MSB first).
    typedef struct packed {
`ifdef INST_ADDR_TRACE_EN
        logic [31:0]              inst_addr;
`endif
        logic [4:0]               rd_addr;
        logic                     rd_write_enable;
        logic [CORE_DATA_W-1:0]   rs1_read_data;
        logic [CORE_DATA_W-1:0]   rs2_read_data;
        logic [CORE_DATA_W-1:0]   imm;
        logic [6:0]               op_code;
        logic [2:0]               funct3;
        logic [6:0]               funct7;
        logic [5:0]               shamt;
        logic [CORE_PID_W-1:0]    pid;
    } du_bundle_t;

    // 223 bits at the defaults, 255 with the trace address.
    localparam int DU_BUNDLE_W = $bits(du_bundle_t);

endpackage

// File: rtl/decode_exec_reg_way1_skid_buffer.sv
// Generic main+skid handshake register with flush.
// valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
// ready_o is decoded from the state register only, so it never depends on ready_i.
module skid_buffer
    import core_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output skid_state_e      state_o
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             in_fire, out_fire;
    logic             load_main, load_skid, main_from_skid;

    assign ready_o  = (state_q != FULL);
    assign valid_o  = (state_q != EMPTY);
    assign data_o   = main_q;
    assign state_o  = state_q;
    assign in_fire  = valid_i && ready_o && !flush_i;
    assign out_fire = valid_o && ready_i;

    // Next-state and register-load decode; flush empties both entries.
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        load_main = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end else if (in_fire) begin
                        load_skid = 1'b1;
                        state_d   = FULL;
                    end else if (out_fire) begin
                        state_d   = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_from_skid = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and payload registers; reset also clears the payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main) begin
                main_q <= data_i;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= data_i;
            end
        end
    end

endmodule

// File: rtl/decode_exec_reg_way1.sv
// Pipeline register between the way1 decoder and the way1 execute unit.
// Optional macro INST_ADDR_TRACE_EN carries a 32-bit instruction address alongside the payload.
module decode_exec_reg_way1
    import core_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int PID_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [4:0]        rdAddr_i,
    input  logic              rdWriteEnable_i,
    input  logic [DATA_W-1:0] rs1ReadData_i,
    input  logic [DATA_W-1:0] rs2ReadData_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [6:0]        opCode_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [5:0]        shamt_i,
    input  logic [PID_W-1:0]  way1_pID_i,
`ifdef INST_ADDR_TRACE_EN
    input  logic [31:0]       instAddr_i,
    output logic [31:0]       instAddr_o,
`endif
    output logic [4:0]        rdAddr_o,
    output logic              rdWriteEnable_o,
    output logic [DATA_W-1:0] rs1ReadData_o,
    output logic [DATA_W-1:0] rs2ReadData_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [6:0]        opCode_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        funct7_o,
    output logic [5:0]        shamt_o,
    output logic [PID_W-1:0]  way1_pID_o,
    output logic              valid_o,
    input  logic              ready_i,
    output skid_state_e       state_o
);

`ifdef INST_ADDR_TRACE_EN
    localparam int TRACE_W = 32;
`else
    localparam int TRACE_W = 0;
`endif
    // Same field order as du_bundle_t, sized from this instance's parameters.
    localparam int BUNDLE_W = TRACE_W + 5 + 1 + 3 * DATA_W + 7 + 3 + 7 + 6 + PID_W;

    logic [BUNDLE_W-1:0] bundle_in, bundle_out;

`ifdef INST_ADDR_TRACE_EN
    assign bundle_in = {instAddr_i, rdAddr_i, rdWriteEnable_i, rs1ReadData_i, rs2ReadData_i,
                        imm_i, opCode_i, funct3_i, funct7_i, shamt_i, way1_pID_i};
    assign {instAddr_o, rdAddr_o, rdWriteEnable_o, rs1ReadData_o, rs2ReadData_o,
            imm_o, opCode_o, funct3_o, funct7_o, shamt_o, way1_pID_o} = bundle_out;
`else
    assign bundle_in = {rdAddr_i, rdWriteEnable_i, rs1ReadData_i, rs2ReadData_i,
                        imm_i, opCode_i, funct3_i, funct7_i, shamt_i, way1_pID_i};
    assign {rdAddr_o, rdWriteEnable_o, rs1ReadData_o, rs2ReadData_o,
            imm_o, opCode_o, funct3_o, funct7_o, shamt_o, way1_pID_o} = bundle_out;
`endif

    skid_buffer #(
        .WIDTH (BUNDLE_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (bundle_in),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (bundle_out),
        .state_o (state_o)
    );

endmodule
